// File: rtl/apb_master_arb_pkg.sv
// Shared constants and types for the two-requester APB master arbiter.
//   NUM_REQ        : number of requesters sharing the APB master
//   APB_AW/DW/SW   : APB address, data and byte-strobe widths
//   ST_*           : FSM state encoding
//   apb_req_t      : captured transfer fields of the granted requester
//   pick_req()     : extracts one requester's fields from the flattened request buses
package apb_master_arb_pkg;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned APB_AW  = 12;
  localparam int unsigned APB_DW  = 32;
  localparam int unsigned APB_SW  = 4;
  localparam int unsigned ST_W    = 2;

  localparam logic [ST_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [ST_W-1:0] ST_SETUP  = 2'd1;
  localparam logic [ST_W-1:0] ST_ACCESS = 2'd2;

  typedef struct packed {
    logic              write;
    logic [APB_AW-1:0] addr;
    logic [APB_DW-1:0] wdata;
    logic [APB_SW-1:0] strb;
  } apb_req_t;

  // Select requester idx's fields out of the per-requester flattened buses.
  function automatic apb_req_t pick_req(
    input logic                      idx,
    input logic [NUM_REQ-1:0]        write,
    input logic [NUM_REQ*APB_AW-1:0] addr,
    input logic [NUM_REQ*APB_DW-1:0] wdata,
    input logic [NUM_REQ*APB_SW-1:0] strb
  );
    apb_req_t r;
    r.write = idx ? write[1]                 : write[0];
    r.addr  = idx ? addr[APB_AW +: APB_AW]   : addr[0 +: APB_AW];
    r.wdata = idx ? wdata[APB_DW +: APB_DW]  : wdata[0 +: APB_DW];
    r.strb  = idx ? strb[APB_SW +: APB_SW]   : strb[0 +: APB_SW];
    return r;
  endfunction

endpackage

// File: rtl/apb_master_arb_if.sv
// Bundles the requester-side handshake and the APB master bus.
//   master modport : the arbiter's view (requests/APB response in, done/APB control out)
//   slave modport  : the environment's view (requesters plus APB slave)
interface apb_master_arb_if;
  import apb_master_arb_pkg::*;

  // requester side
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*APB_AW-1:0] req_addr;
  logic [NUM_REQ*APB_DW-1:0] req_wdata;
  logic [NUM_REQ*APB_SW-1:0] req_strb;
  logic [NUM_REQ-1:0]        req_done;
  logic [APB_DW-1:0]         rsp_rdata;
  logic                      rsp_err;

  // APB side
  logic                      psel;
  logic                      penable;
  logic                      pwrite;
  logic [APB_AW-1:0]         paddr;
  logic [APB_DW-1:0]         pwdata;
  logic [APB_SW-1:0]         pstrb;
  logic                      pready;
  logic                      pslverr;
  logic [APB_DW-1:0]         prdata;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_strb,
    input  pready, pslverr, prdata,
    output req_done, rsp_rdata, rsp_err,
    output psel, penable, pwrite, paddr, pwdata, pstrb
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_strb,
    output pready, pslverr, prdata,
    input  req_done, rsp_rdata, rsp_err,
    input  psel, penable, pwrite, paddr, pwdata, pstrb
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant (combinational).
//   i_req          : eligible requests, bit n = requester n
//   i_last_grant   : index of the most recently granted requester
//   o_gnt_valid_c  : some requester is granted
//   o_gnt_idx_c    : granted requester index
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic       o_gnt_valid_c,
  output logic       o_gnt_idx_c
);

  // Under contention the requester that did not win last time goes next.
  always_comb begin
    o_gnt_valid_c = |i_req;
    if (i_req == 2'b11) o_gnt_idx_c = ~i_last_grant;
    else                o_gnt_idx_c = i_req[1];
  end

endmodule

// File: rtl/apb_master_arb.sv
// APB master shared by two requesters with round-robin arbitration and
// a pready timeout.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : requester handshake + APB master signals (master modport)
//   TIMEOUT    : ACCESS cycles with pready low before the transfer is abandoned
module apb_master_arb
  import apb_master_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  apb_master_arb_if.master   bus
);

  localparam int unsigned WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [ST_W-1:0]    r_state,   w_state_nxt;
  logic               r_psel,    w_psel_nxt;
  logic               r_penable, w_penable_nxt;
  apb_req_t           r_cap,     w_cap_nxt;
  logic               r_gidx,    w_gidx_nxt;
  logic               r_last,    w_last_nxt;
  logic [WCW-1:0]     r_wait,    w_wait_nxt;
  logic [NUM_REQ-1:0] r_done,    w_done_nxt;
  logic [APB_DW-1:0]  r_rdata,   w_rdata_nxt;
  logic               r_err,     w_err_nxt;

  logic [NUM_REQ-1:0] w_elig;
  logic               w_gnt_valid;
  logic               w_gnt_idx;

  // A requester whose done pulse is showing this cycle cannot be re-granted.
  assign w_elig = bus.req_valid & ~r_done;

  rr_arb2 u_rr_arb2 (
    .i_req         (w_elig),
    .i_last_grant  (r_last),
    .o_gnt_valid_c (w_gnt_valid),
    .o_gnt_idx_c   (w_gnt_idx)
  );

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_cap     <= '0;
      r_gidx    <= 1'b0;
      r_last    <= 1'b1;
      r_wait    <= '0;
      r_done    <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_psel    <= w_psel_nxt;
      r_penable <= w_penable_nxt;
      r_cap     <= w_cap_nxt;
      r_gidx    <= w_gidx_nxt;
      r_last    <= w_last_nxt;
      r_wait    <= w_wait_nxt;
      r_done    <= w_done_nxt;
      r_rdata   <= w_rdata_nxt;
      r_err     <= w_err_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_psel_nxt    = r_psel;
    w_penable_nxt = r_penable;
    w_cap_nxt     = r_cap;
    w_gidx_nxt    = r_gidx;
    w_last_nxt    = r_last;
    w_wait_nxt    = r_wait;
    w_done_nxt    = '0;
    w_rdata_nxt   = r_rdata;
    w_err_nxt     = r_err;

    case (r_state)
      ST_IDLE: begin
        if (w_gnt_valid) begin
          w_cap_nxt     = pick_req(w_gnt_idx, bus.req_write, bus.req_addr,
                                   bus.req_wdata, bus.req_strb);
          w_gidx_nxt    = w_gnt_idx;
          w_last_nxt    = w_gnt_idx;
          w_wait_nxt    = '0;
          w_state_nxt   = ST_SETUP;
          w_psel_nxt    = 1'b1;
          w_penable_nxt = 1'b0;
        end
      end

      ST_SETUP: begin
        w_state_nxt   = ST_ACCESS;
        w_psel_nxt    = 1'b1;
        w_penable_nxt = 1'b1;
      end

      ST_ACCESS: begin
        // pready wins over the timeout when both happen on the same cycle.
        if (bus.pready) begin
          w_rdata_nxt        = r_cap.write ? '0 : bus.prdata;
          w_err_nxt          = bus.pslverr;
          w_done_nxt[r_gidx] = 1'b1;
          w_state_nxt        = ST_IDLE;
          w_psel_nxt         = 1'b0;
          w_penable_nxt      = 1'b0;
        end else if (r_wait == WCW'(TIMEOUT - 1)) begin
          w_rdata_nxt        = '0;
          w_err_nxt          = 1'b1;
          w_done_nxt[r_gidx] = 1'b1;
          w_state_nxt        = ST_IDLE;
          w_psel_nxt         = 1'b0;
          w_penable_nxt      = 1'b0;
        end else begin
          w_wait_nxt = r_wait + WCW'(1);
        end
      end

      default: begin
        w_state_nxt   = ST_IDLE;
        w_psel_nxt    = 1'b0;
        w_penable_nxt = 1'b0;
      end
    endcase
  end

  assign bus.psel      = r_psel;
  assign bus.penable   = r_penable;
  assign bus.pwrite    = r_cap.write;
  assign bus.paddr     = r_cap.addr;
  assign bus.pwdata    = r_cap.wdata;
  assign bus.pstrb     = r_cap.strb;
  assign bus.req_done  = r_done;
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;

endmodule
